// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file's single write port: three valid/ready sources,
// registered output stage, R0 write suppression and forwarding. WBARB_ROUND_ROBIN_EN selects rotating priority.
module regfile_wb_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          src_valid,
  input  logic [3*ADDR_W-1:0] src_addr,
  input  logic [3*DATA_W-1:0] src_data,
  output logic [2:0]          src_ready,
  input  logic                wb_stall,
  output logic                rf_we,
  output logic [ADDR_W-1:0]   rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic                fwd_hit,
  output logic [DATA_W-1:0]   fwd_data
);

  logic [2:0]        gnt;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

`ifdef WBARB_ROUND_ROBIN_EN
  logic [1:0] ptr_q, ptr_d, ptr_eff;

  always_comb begin
    ptr_eff = (ptr_q == 2'd3) ? 2'd0 : ptr_q;
    gnt = 3'b000;
    case (ptr_eff)
      2'd1: begin
        if      (src_valid[1]) gnt = 3'b010;
        else if (src_valid[2]) gnt = 3'b100;
        else if (src_valid[0]) gnt = 3'b001;
      end
      2'd2: begin
        if      (src_valid[2]) gnt = 3'b100;
        else if (src_valid[0]) gnt = 3'b001;
        else if (src_valid[1]) gnt = 3'b010;
      end
      default: begin
        if      (src_valid[0]) gnt = 3'b001;
        else if (src_valid[1]) gnt = 3'b010;
        else if (src_valid[2]) gnt = 3'b100;
      end
    endcase
  end

  // Pointer moves just past the granted source; idle and stalled cycles leave it alone.
  always_comb begin
    ptr_d = ptr_q;
    if (src_ready[0])      ptr_d = 2'd1;
    else if (src_ready[1]) ptr_d = 2'd2;
    else if (src_ready[2]) ptr_d = 2'd0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= 2'd0;
    else        ptr_q <= ptr_d;
  end
`else
  always_comb begin
    gnt = 3'b000;
    if      (src_valid[0]) gnt = 3'b001;
    else if (src_valid[1]) gnt = 3'b010;
    else if (src_valid[2]) gnt = 3'b100;
  end
`endif

  assign src_ready = (rst_n && !wb_stall) ? gnt : 3'b000;

  always_comb begin
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (src_ready[i] && (src_addr[i*ADDR_W +: ADDR_W] != '0)) begin
        we_d    = 1'b1;
        waddr_d = src_addr[i*ADDR_W +: ADDR_W];
        wdata_d = src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign rf_we    = we_q;
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;

  // Forward the write being committed this cycle; R0 never forwards.
  assign fwd_hit  = we_q && (waddr_q == rd_addr) && (rd_addr != '0);
  assign fwd_data = fwd_hit ? wdata_q : '0;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed literal checks plus a randomized run against a behavioural model.
module tb_regfile_wb_arbiter;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [2:0]          src_valid;
  logic [3*ADDR_W-1:0] src_addr;
  logic [3*DATA_W-1:0] src_data;
  logic [2:0]          src_ready;
  logic                wb_stall;
  logic                rf_we;
  logic [ADDR_W-1:0]   rf_waddr;
  logic [DATA_W-1:0]   rf_wdata;
  logic [ADDR_W-1:0]   rd_addr;
  logic                fwd_hit;
  logic [DATA_W-1:0]   fwd_data;

  regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_addr(src_addr),
    .src_data(src_data), .src_ready(src_ready), .wb_stall(wb_stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rd_addr(rd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: write-port contents plus rotating priority pointer
  bit                m_known = 1'b0;
  bit                m_we;
  logic [ADDR_W-1:0] m_waddr;
  logic [DATA_W-1:0] m_wdata;
  int                m_ptr;
  logic [2:0]        m_gnt = 3'b000;

  function automatic logic [2:0] model_gnt(input logic [2:0] v, input int p);
    for (int k = 0; k < 3; k++) begin
      int s;
      s = (p + k) % 3;
      if (v[s]) return 3'(1 << s);
    end
    return 3'b000;
  endfunction

  always @(negedge clk) begin
    logic [2:0] eg;
    bit eh;
    eg = (rst_n && !wb_stall) ? model_gnt(src_valid, m_ptr) : 3'b000;
    if (m_known) begin
      eh = m_we && (m_waddr == rd_addr) && (rd_addr != 0);
      chk("src_ready", 32'(src_ready), 32'(eg));
      chk("rf_we", 32'(rf_we), 32'(m_we));
      chk("rf_waddr", 32'(rf_waddr), 32'(m_waddr));
      chk("rf_wdata", 32'(rf_wdata), 32'(m_wdata));
      chk("fwd_hit", 32'(fwd_hit), 32'(eh));
      chk("fwd_data", 32'(fwd_data), eh ? 32'(m_wdata) : 32'd0);
    end
    if (!rst_n) begin
      m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_ptr = 0; m_known = 1'b1;
    end else if (m_known) begin
      m_we = 1'b0;
      for (int s = 0; s < 3; s++) begin
        if (eg[s]) begin
          if (src_addr[s*ADDR_W +: ADDR_W] != 0) begin
            m_we    = 1'b1;
            m_waddr = src_addr[s*ADDR_W +: ADDR_W];
            m_wdata = src_data[s*DATA_W +: DATA_W];
          end
`ifdef WBARB_ROUND_ROBIN_EN
          m_ptr = (s + 1) % 3;
`endif
        end
      end
    end
    m_gnt = eg;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    src_addr[i*ADDR_W +: ADDR_W] = a;
    src_data[i*DATA_W +: DATA_W] = d;
  endtask

  logic [2:0] rr_seq [6];
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_data;

  initial begin
`ifdef WBARB_ROUND_ROBIN_EN
    rr_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    r0_addr = 3'd6; r0_data = 16'hA002;
`else
    rr_seq = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
    r0_addr = 3'd1; r0_data = 16'hA000;
`endif
    rst_n = 1'b0; wb_stall = 1'b0; rd_addr = '0;
    src_valid = 3'b111; src_addr = '0; src_data = '0;
    set_src(0, 3'd1, 16'hA000);
    set_src(1, 3'd2, 16'hA001);
    set_src(2, 3'd6, 16'hA002);

    // Reset held with all sources requesting
    step();
    @(negedge clk);
    chk("rst_ready", 32'(src_ready), 32'd0);
    chk("rst_we", 32'(rf_we), 32'd0);
    chk("rst_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_wdata", 32'(rf_wdata), 32'd0);
    step();
    rst_n = 1'b1;

    // First grant after release, then the six-cycle priority sequence
    for (int c = 0; c < 6; c++) begin
      if (c > 0) step();
      @(negedge clk);
      chk("rr_grant", 32'(src_ready), 32'(rr_seq[c]));
    end

    // R0 write: handshake completes, write suppressed, output stage holds
    step();
    src_valid = 3'b001; set_src(0, 3'd0, 16'h1234);
    @(negedge clk);
    chk("r0_ready", 32'(src_ready), 32'b001);
    step();
    src_valid = 3'b000; rd_addr = 3'd0;
    @(negedge clk);
    chk("r0_we", 32'(rf_we), 32'd0);
    chk("r0_waddr", 32'(rf_waddr), 32'(r0_addr));
    chk("r0_wdata", 32'(rf_wdata), 32'(r0_data));
    chk("r0_fwd", 32'(fwd_hit), 32'd0);

    // Stall with source 2 waiting
    step();
    wb_stall = 1'b1; src_valid = 3'b100; set_src(2, 3'd3, 16'h00A5);
    for (int c = 0; c < 3; c++) begin
      if (c > 0) step();
      @(negedge clk);
      chk("stall_ready", 32'(src_ready), 32'd0);
    end
    step();
    wb_stall = 1'b0;
    @(negedge clk);
    chk("stall_rel_ready", 32'(src_ready), 32'b100);
    step();
    src_valid = 3'b000; wb_stall = 1'b1;
    @(negedge clk);
    chk("stall_we", 32'(rf_we), 32'd1);
    chk("stall_waddr", 32'(rf_waddr), 32'd3);
    chk("stall_wdata", 32'(rf_wdata), 32'h00A5);

    // Forwarding
    step();
    wb_stall = 1'b0; src_valid = 3'b010; set_src(1, 3'd4, 16'h7777);
    @(negedge clk);
    chk("fwd_ready", 32'(src_ready), 32'b010);
    step();
    src_valid = 3'b000; rd_addr = 3'd4;
    @(negedge clk);
    chk("fwd_hit4", 32'(fwd_hit), 32'd1);
    chk("fwd_data4", 32'(fwd_data), 32'h7777);
    #1 rd_addr = 3'd2;
    #1;
    chk("fwd_hit2", 32'(fwd_hit), 32'd0);
    chk("fwd_data2", 32'(fwd_data), 32'd0);
    step();
    rd_addr = 3'd4; src_valid = 3'b001; set_src(0, 3'd0, 16'hFFFF);
    step();
    src_valid = 3'b000;
    @(negedge clk);
    chk("fwd_r0_hit", 32'(fwd_hit), 32'd0);
    chk("fwd_r0_data", 32'(fwd_data), 32'd0);

    // Single write from source 1
    step();
    src_valid = 3'b010; set_src(1, 3'd5, 16'hBEEF);
    @(negedge clk);
    chk("single_ready", 32'(src_ready), 32'b010);
    step();
    src_valid = 3'b000;
    @(negedge clk);
    chk("single_we", 32'(rf_we), 32'd1);
    chk("single_waddr", 32'(rf_waddr), 32'd5);
    chk("single_wdata", 32'(rf_wdata), 32'hBEEF);
    step();
    @(negedge clk);
    chk("single_we_clr", 32'(rf_we), 32'd0);

    // Randomized traffic; a waiting source holds its request until granted
    for (int c = 0; c < 3000; c++) begin
      step();
      rst_n    = ($urandom_range(0, 63) != 0);
      wb_stall = ($urandom_range(0, 3) == 0);
      rd_addr  = ADDR_W'($urandom);
      for (int i = 0; i < 3; i++) begin
        if (!src_valid[i] || m_gnt[i]) begin
          src_valid[i] = ($urandom_range(0, 2) != 0);
          set_src(i, ADDR_W'($urandom), DATA_W'($urandom));
        end
      end
    end
    step();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end
endmodule
